// File: rtl/step_pkg.sv
// step_pkg: shared types and default widths for the step pulse generator.
//   state_t          - controller state encoding (IDLE, SETUP, RUN)
//   CNT_W_DEFAULT    - default width of the period / pulse-width counters
//   STEPS_W_DEFAULT  - default width of the step-count register
package step_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_RUN   = 2'd2
  } state_t;

  localparam int CNT_W_DEFAULT   = 21;
  localparam int STEPS_W_DEFAULT = 16;

endpackage

// File: rtl/step_pulse_gen.sv
// step_pulse_gen: step/direction pulse generator for a stepper driver.
// A start request latches direction, mode, step count and rate. After an
// optional direction setup delay, a train of step pulses is produced with
// period (period_eff+1) cycles and high time pw_eff. Rate changes take effect
// only at step boundaries. Counted mode stops after 'steps' pulses with a
// one-cycle done pulse; continuous mode runs until en falls.
// Ports:
//   clk, rst            clock, asynchronous active-low reset
//   en                  enable, low aborts
//   start               start request (honoured only in IDLE)
//   mode                0 = continuous, 1 = counted burst
//   period, pulse_w     step period minus one, step high time
//   steps               burst length in counted mode
//   dir_in              requested direction
//   step_out, dir_out   registered step pulse and direction
//   busy, done          activity flag, burst completion pulse
//   steps_left          remaining steps in counted mode
module step_pulse_gen
  import step_pkg::*;
#(
  parameter int CNT_W     = CNT_W_DEFAULT,
  parameter int STEPS_W   = STEPS_W_DEFAULT,
  parameter int DIR_SETUP = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               start,
  input  logic               mode,
  input  logic [CNT_W-1:0]   period,
  input  logic [CNT_W-1:0]   pulse_w,
  input  logic [STEPS_W-1:0] steps,
  input  logic               dir_in,
  output logic               step_out,
  output logic               dir_out,
  output logic               busy,
  output logic               done,
  output logic [STEPS_W-1:0] steps_left
);

  localparam logic [CNT_W-1:0]   CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [STEPS_W-1:0] STEPS_ONE = {{(STEPS_W-1){1'b0}}, 1'b1};
  // SETUP reuses the step counter; it leaves SETUP when the counter reaches this.
  localparam logic [CNT_W-1:0]   SETUP_LAST = (DIR_SETUP > 0) ? CNT_W'(DIR_SETUP - 1) : '0;

  // A zero period would give a one-cycle step with no low phase; clamp to 1.
  function automatic logic [CNT_W-1:0] eff_period(input logic [CNT_W-1:0] p);
    return (p == '0) ? CNT_ONE : p;
  endfunction

  // High time is clamped so each step keeps at least one low cycle and one high cycle.
  function automatic logic [CNT_W-1:0] eff_pw(input logic [CNT_W-1:0] pw,
                                              input logic [CNT_W-1:0] pe);
    logic [CNT_W-1:0] m;
    m = (pw < pe) ? pw : pe;
    return (m == '0) ? CNT_ONE : m;
  endfunction

  state_t             state_r, state_s;
  logic [CNT_W-1:0]   count_r, count_s;
  logic [CNT_W-1:0]   period_sh_r, period_sh_s;
  logic [CNT_W-1:0]   pw_sh_r, pw_sh_s;
  logic               mode_r, mode_s;
  logic               step_out_s, dir_s, busy_s, done_s;
  logic [STEPS_W-1:0] steps_left_s;
  logic [CNT_W-1:0]   pe_s, pwe_s;

  assign pe_s  = eff_period(period_sh_r);
  assign pwe_s = eff_pw(pw_sh_r, pe_s);

  // Next-state and next-output logic of the controller.
  always_comb begin
    state_s      = state_r;
    count_s      = count_r;
    period_sh_s  = period_sh_r;
    pw_sh_s      = pw_sh_r;
    mode_s       = mode_r;
    step_out_s   = 1'b0;
    dir_s        = dir_out;
    busy_s       = busy;
    done_s       = 1'b0;
    steps_left_s = steps_left;
    case (state_r)
      ST_IDLE: begin
        if (en && start) begin
          dir_s       = dir_in;
          mode_s      = mode;
          period_sh_s = period;
          pw_sh_s     = pulse_w;
          count_s     = '0;
          if (mode && (steps == '0)) begin
            // Empty burst: complete immediately without leaving IDLE.
            done_s       = 1'b1;
            busy_s       = 1'b0;
            steps_left_s = '0;
          end else begin
            busy_s       = 1'b1;
            steps_left_s = mode ? steps : '0;
            if (DIR_SETUP > 0) begin
              state_s = ST_SETUP;
            end else begin
              state_s    = ST_RUN;
              step_out_s = 1'b1;
            end
          end
        end else begin
          busy_s = 1'b0;
        end
      end
      ST_SETUP: begin
        if (!en) begin
          state_s = ST_IDLE;
          busy_s  = 1'b0;
        end else if (count_r == SETUP_LAST) begin
          state_s    = ST_RUN;
          count_s    = '0;
          step_out_s = 1'b1;
        end else begin
          count_s = count_r + CNT_ONE;
        end
      end
      ST_RUN: begin
        if (!en) begin
          state_s = ST_IDLE;
          busy_s  = 1'b0;
        end else if (count_r == pe_s) begin
          // Step boundary: the only point where new rate inputs are accepted.
          count_s     = '0;
          period_sh_s = period;
          pw_sh_s     = pulse_w;
          if (mode_r) begin
            steps_left_s = steps_left - STEPS_ONE;
            if (steps_left == STEPS_ONE) begin
              state_s = ST_IDLE;
              busy_s  = 1'b0;
              done_s  = 1'b1;
            end else begin
              step_out_s = 1'b1;
            end
          end else begin
            step_out_s = 1'b1;
          end
        end else begin
          count_s    = count_r + CNT_ONE;
          step_out_s = ((count_r + CNT_ONE) < pwe_s);
        end
      end
      default: begin
        state_s = ST_IDLE;
        busy_s  = 1'b0;
      end
    endcase
  end

  // State, counter, shadow and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r     <= ST_IDLE;
      count_r     <= '0;
      period_sh_r <= '0;
      pw_sh_r     <= '0;
      mode_r      <= 1'b0;
      step_out    <= 1'b0;
      dir_out     <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      steps_left  <= '0;
    end else begin
      state_r     <= state_s;
      count_r     <= count_s;
      period_sh_r <= period_sh_s;
      pw_sh_r     <= pw_sh_s;
      mode_r      <= mode_s;
      step_out    <= step_out_s;
      dir_out     <= dir_s;
      busy        <= busy_s;
      done        <= done_s;
      steps_left  <= steps_left_s;
    end
  end

endmodule

// File: tb/tb_step_pulse_gen.sv
// tb_step_pulse_gen: directed scenarios plus randomized stimulus for
// step_pulse_gen, compared every cycle against a timeline model that tracks
// step start times and step lengths.
module tb_step_pulse_gen;

  localparam int CNT_W   = 21;
  localparam int STEPS_W = 16;
  localparam int D       = 4;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic               en = 1'b0;
  logic               start = 1'b0;
  logic               mode = 1'b0;
  logic [CNT_W-1:0]   period = '0;
  logic [CNT_W-1:0]   pulse_w = '0;
  logic [STEPS_W-1:0] steps = '0;
  logic               dir_in = 1'b0;
  logic               step_out, dir_out, busy, done;
  logic [STEPS_W-1:0] steps_left;

  step_pulse_gen #(.CNT_W(CNT_W), .STEPS_W(STEPS_W), .DIR_SETUP(D)) dut (
    .clk(clk), .rst(rst), .en(en), .start(start), .mode(mode),
    .period(period), .pulse_w(pulse_w), .steps(steps), .dir_in(dir_in),
    .step_out(step_out), .dir_out(dir_out), .busy(busy), .done(done),
    .steps_left(steps_left)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: a burst is a sequence of steps; each step begins at an
  // edge index and lasts m_len edges, of which the first m_pw are high.
  int e;
  bit m_active, m_done, m_dir, m_mode;
  int m_left, m_begin, m_len, m_pw;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", tag, got, exp, e);
    end
  endtask

  task automatic model_reset();
    e = 0; m_active = 0; m_done = 0; m_dir = 0; m_mode = 0;
    m_left = 0; m_begin = 0; m_len = 2; m_pw = 1;
  endtask

  task automatic set_rate();
    int pe, pw;
    pe = (int'(period) == 0) ? 1 : int'(period);
    pw = (int'(pulse_w) < pe) ? int'(pulse_w) : pe;
    m_len = pe + 1;
    m_pw  = (pw == 0) ? 1 : pw;
  endtask

  task automatic model_edge();
    m_done = 0;
    if (!m_active) begin
      if (en && start) begin
        m_dir = dir_in;
        if (mode && steps == '0) begin
          m_done = 1;
          m_left = 0;
        end else begin
          m_active = 1;
          m_mode   = mode;
          m_left   = mode ? int'(steps) : 0;
          m_begin  = e + D;
          set_rate();
        end
      end
    end else if (!en) begin
      m_active = 0;
    end else if (e == m_begin + m_len) begin
      if (m_mode) begin
        m_left--;
        if (m_left == 0) begin
          m_active = 0;
          m_done   = 1;
        end
      end
      if (m_active) begin
        m_begin = e;
        set_rate();
      end
    end
  endtask

  task automatic compare_all();
    bit exp_step;
    exp_step = m_active && (e >= m_begin) && ((e - m_begin) < m_pw);
    check("step_out", 32'(step_out), 32'(exp_step));
    check("dir_out", 32'(dir_out), 32'(m_dir));
    check("busy", 32'(busy), 32'(m_active));
    check("done", 32'(done), 32'(m_done));
    check("steps_left", 32'(steps_left), 32'(m_left));
  endtask

  task automatic cycle();
    @(posedge clk);
    if (!rst) begin
      model_reset();
    end else begin
      e++;
      model_edge();
    end
    #1;
    compare_all();
  endtask

  task automatic set_inputs(input bit m, input int p, input int pw, input int s, input bit d);
    mode = m; period = CNT_W'(p); pulse_w = CNT_W'(pw); steps = STEPS_W'(s); dir_in = d;
  endtask

  int k, first_rise, done_at, highs, nrise;
  int rises[$];
  bit prev;

  initial begin
    model_reset();
    #1;
    compare_all();
    cycle();
    #2 rst = 1'b1;
    en = 1'b1;
    cycle();

    // Counted burst: 5 steps, period 9, pulse 3.
    set_inputs(1'b1, 9, 3, 5, 1'b1);
    start = 1'b1;
    cycle();
    start = 1'b0;
    k = e; first_rise = -1; done_at = -1; highs = 0;
    check("burst_dir", 32'(dir_out), 32'd1);
    for (int i = 0; i < 60; i++) begin
      if (i == 20) dir_in = 1'b0;
      cycle();
      if (step_out) begin
        highs++;
        if (first_rise < 0) first_rise = e - k;
      end
      if (done && done_at < 0) done_at = e - k;
    end
    check("first_rise", 32'(first_rise), 32'd4);
    check("done_edge", 32'(done_at), 32'd54);
    check("high_cycles", 32'(highs), 32'd15);
    check("busy_after", 32'(busy), 32'd0);

    // Continuous mode with a rate change in the middle of a step.
    set_inputs(1'b0, 9, 3, 0, 1'b0);
    start = 1'b1;
    cycle();
    start = 1'b0;
    k = e; prev = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (i == 17) period = CNT_W'(19);
      cycle();
      if (step_out && !prev) rises.push_back(e - k);
      prev = step_out;
    end
    nrise = rises.size();
    check("rise_count", 32'(nrise), 32'd4);
    if (nrise >= 4) begin
      check("step_before_change", 32'(rises[2] - rises[1]), 32'd10);
      check("step_after_change", 32'(rises[3] - rises[2]), 32'd20);
    end
    en = 1'b0;
    cycle();
    en = 1'b1;

    // Abort after the second wrap of a 3-step burst.
    set_inputs(1'b1, 4, 10, 3, 1'b1);
    start = 1'b1;
    cycle();
    start = 1'b0;
    for (int i = 0; i < 40 && steps_left != STEPS_W'(1); i++) cycle();
    check("abort_left_before", 32'(steps_left), 32'd1);
    en = 1'b0;
    cycle();
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_left", 32'(steps_left), 32'd1);
    en = 1'b1;

    // Empty counted burst.
    set_inputs(1'b1, 0, 0, 0, 1'b0);
    start = 1'b1;
    cycle();
    start = 1'b0;
    check("empty_done", 32'(done), 32'd1);
    check("empty_busy", 32'(busy), 32'd0);
    cycle();
    check("empty_done_clear", 32'(done), 32'd0);

    // Randomized traffic.
    for (int i = 0; i < 4000; i++) begin
      en     = ($urandom_range(0, 59) != 0);
      start  = ($urandom_range(0, 11) == 0);
      mode   = 1'($urandom_range(0, 1));
      dir_in = 1'($urandom_range(0, 1));
      steps  = STEPS_W'($urandom_range(0, 4));
      if ($urandom_range(0, 7) == 0) begin
        period  = CNT_W'($urandom_range(0, 12));
        pulse_w = CNT_W'($urandom_range(0, 14));
      end
      cycle();
    end

    // Asynchronous reset in the middle of a pulse.
    en = 1'b0;
    cycle();
    en = 1'b1;
    set_inputs(1'b1, 9, 5, 4, 1'b1);
    start = 1'b1;
    cycle();
    start = 1'b0;
    for (int i = 0; i < 20 && !step_out; i++) cycle();
    check("rise_before_reset", 32'(step_out), 32'd1);
    #2 rst = 1'b0;
    #1;
    check("async_step_out", 32'(step_out), 32'd0);
    check("async_busy", 32'(busy), 32'd0);
    check("async_steps_left", 32'(steps_left), 32'd0);
    check("async_dir_out", 32'(dir_out), 32'd0);
    model_reset();
    cycle();
    #2 rst = 1'b1;
    for (int i = 0; i < 5; i++) cycle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
